pipe_stage_skid: RTL and testbench

//   Parametrised pipeline stage register; successor to the fixed MEM/WB register.

---
 rtl/pipe_stage_skid.sv | 136 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage register with optional 2-entry skid buffer, flush and a
// saturating stall counter.
module pipe_stage_skid #(
    parameter int unsigned DATA_W = 71,
    parameter int unsigned CTRL_W = 2,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              mainValidQ, mainValidD;
    logic [DATA_W-1:0] mainDataQ, mainDataD;
    logic [CTRL_W-1:0] mainCtrlQ, mainCtrlD;
    logic              skidValidQ, skidValidD;
    logic [DATA_W-1:0] skidDataQ, skidDataD;
    logic [CTRL_W-1:0] skidCtrlQ, skidCtrlD;
    logic [CNT_W-1:0]  stallCntQ, stallCntD;
    logic              inFire, outFire;

    // With the skid buffer, in_ready comes straight from a flop and never sees out_ready.
    always_comb begin
        if (SKID != 0) begin
            in_ready = !skidValidQ;
        end else begin
            in_ready = !mainValidQ || out_ready;
        end
    end

    assign inFire    = in_valid && in_ready;
    assign outFire   = mainValidQ && out_ready;
    assign out_valid = mainValidQ;
    assign out_data  = mainDataQ;
    assign out_ctrl  = mainValidQ ? mainCtrlQ : '0;
    assign stall_cnt = stallCntQ;

    always_comb begin
        mainValidD = mainValidQ;
        mainDataD  = mainDataQ;
        mainCtrlD  = mainCtrlQ;
        skidValidD = skidValidQ;
        skidDataD  = skidDataQ;
        skidCtrlD  = skidCtrlQ;

        if (flush) begin
            // Data is left alone; only validity and control must not leak.
            mainValidD = 1'b0;
            mainCtrlD  = '0;
            skidValidD = 1'b0;
            skidCtrlD  = '0;
        end else if (SKID != 0) begin
            case ({mainValidQ, skidValidQ})
                2'b00: begin
                    if (inFire) begin
                        mainValidD = 1'b1;
                        mainDataD  = in_data;
                        mainCtrlD  = in_ctrl;
                    end
                end
                2'b10: begin
                    if (inFire && outFire) begin
                        mainDataD = in_data;
                        mainCtrlD = in_ctrl;
                    end else if (inFire) begin
                        skidValidD = 1'b1;
                        skidDataD  = in_data;
                        skidCtrlD  = in_ctrl;
                    end else if (outFire) begin
                        mainValidD = 1'b0;
                        mainCtrlD  = '0;
                    end
                end
                2'b11: begin
                    if (outFire) begin
                        mainDataD  = skidDataQ;
                        mainCtrlD  = skidCtrlQ;
                        skidValidD = 1'b0;
                        skidCtrlD  = '0;
                    end
                end
                default: begin
                    skidValidD = 1'b0;
                    skidCtrlD  = '0;
                end
            endcase
        end else begin
            if (inFire) begin
                mainValidD = 1'b1;
                mainDataD  = in_data;
                mainCtrlD  = in_ctrl;
            end else if (outFire) begin
                mainValidD = 1'b0;
                mainCtrlD  = '0;
            end
        end
    end

    always_comb begin
        stallCntD = stallCntQ;
        if (mainValidQ && !out_ready && (stallCntQ != {CNT_W{1'b1}})) begin
            stallCntD = stallCntQ + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mainValidQ <= 1'b0;
            mainDataQ  <= '0;
            mainCtrlQ  <= '0;
            skidValidQ <= 1'b0;
            skidDataQ  <= '0;
            skidCtrlQ  <= '0;
            stallCntQ  <= '0;
        end else begin
            mainValidQ <= mainValidD;
            mainDataQ  <= mainDataD;
            mainCtrlQ  <= mainCtrlD;
            skidValidQ <= skidValidD;
            skidDataQ  <= skidDataD;
            skidCtrlQ  <= skidCtrlD;
            stallCntQ  <= stallCntD;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench: instance 0 is SKID=1, instance 1 is SKID=0, instance 2 is SKID=1 with a
// 4-bit stall counter. All share the same input stimulus.
module tb_pipe_stage_skid;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       inValid;
    logic [7:0] inData;
    logic [1:0] inCtrl;
    logic       outReady;

    logic        inReady [3];
    logic        outValid[3];
    logic [7:0]  outData [3];
    logic [1:0]  outCtrl [3];
    logic [15:0] stallCnt[2];
    logic [3:0]  stallC;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(8), .CTRL_W(2), .SKID(1), .CNT_W(16)) dutSkid (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(inValid), .in_ready(inReady[0]), .in_data(inData), .in_ctrl(inCtrl),
        .out_valid(outValid[0]), .out_ready(outReady), .out_data(outData[0]),
        .out_ctrl(outCtrl[0]), .stall_cnt(stallCnt[0])
    );

    pipe_stage_skid #(.DATA_W(8), .CTRL_W(2), .SKID(0), .CNT_W(16)) dutSingle (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(inValid), .in_ready(inReady[1]), .in_data(inData), .in_ctrl(inCtrl),
        .out_valid(outValid[1]), .out_ready(outReady), .out_data(outData[1]),
        .out_ctrl(outCtrl[1]), .stall_cnt(stallCnt[1])
    );

    pipe_stage_skid #(.DATA_W(8), .CTRL_W(2), .SKID(1), .CNT_W(4)) dutSat (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(inValid), .in_ready(inReady[2]), .in_data(inData), .in_ctrl(inCtrl),
        .out_valid(outValid[2]), .out_ready(outReady), .out_data(outData[2]),
        .out_ctrl(outCtrl[2]), .stall_cnt(stallC)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        reset = 1'b0; flush = 1'b0; inValid = 1'b0; inData = '0; inCtrl = '0; outReady = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; inValid = 1'b0; inData = '0; inCtrl = '0; outReady = 1'b0;
        #2;
        for (int d = 0; d < 3; d++) begin
            checks++; if (outValid[d] !== 1'b0) begin errors++;
                $display("FAIL reset_valid dut%0d: got %b want 0", d, outValid[d]); end
            checks++; if (outCtrl[d] !== 2'b00) begin errors++;
                $display("FAIL reset_ctrl dut%0d: got %b want 00", d, outCtrl[d]); end
            checks++; if (outData[d] !== 8'h00) begin errors++;
                $display("FAIL reset_data dut%0d: got %h want 00", d, outData[d]); end
            checks++; if (inReady[d] !== 1'b1) begin errors++;
                $display("FAIL reset_in_ready dut%0d: got %b want 1", d, inReady[d]); end
        end
        checks++; if (stallCnt[0] !== 16'd0 || stallCnt[1] !== 16'd0 || stallC !== 4'd0) begin
            errors++;
            $display("FAIL reset_stall: got %0d/%0d/%0d want 0", stallCnt[0], stallCnt[1], stallC);
        end
        step();
        reset = 1'b1;
    endtask

    task automatic test_stream(input int d);
        logic [7:0] vals[3];
        vals = '{8'h11, 8'h22, 8'h33};
        applyReset();
        outReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                inValid = 1'b1; inData = vals[i]; inCtrl = 2'(i + 1);
            end else begin
                inValid = 1'b0;
            end
            @(negedge clk);
            checks++; if (inReady[d] !== 1'b1) begin errors++;
                $display("FAIL stream_in_ready dut%0d i=%0d: got %b want 1", d, i, inReady[d]); end
            if (i == 0) begin
                checks++; if (outValid[d] !== 1'b0) begin errors++;
                    $display("FAIL stream_first_valid dut%0d: got %b want 0", d, outValid[d]); end
            end else begin
                checks++; if (outValid[d] !== 1'b1) begin errors++;
                    $display("FAIL stream_valid dut%0d i=%0d: got %b want 1", d, i, outValid[d]); end
                checks++; if (outData[d] !== vals[i-1]) begin errors++;
                    $display("FAIL stream_data dut%0d i=%0d: got %h want %h", d, i, outData[d],
                             vals[i-1]); end
                checks++; if (outCtrl[d] !== 2'(i)) begin errors++;
                    $display("FAIL stream_ctrl dut%0d i=%0d: got %b want %b", d, i, outCtrl[d],
                             2'(i)); end
            end
            step();
        end
        @(negedge clk);
        checks++; if (outValid[d] !== 1'b0 || outCtrl[d] !== 2'b00) begin errors++;
            $display("FAIL stream_drain dut%0d: got v=%b c=%b want v=0 c=00", d, outValid[d],
                     outCtrl[d]); end
    endtask

    task automatic test_stall_fill(input int d);
        logic skid;
        skid = (d == 0);
        applyReset();
        outReady = 1'b0; inValid = 1'b1; inData = 8'h05; inCtrl = 2'd1;
        @(negedge clk);
        checks++; if (inReady[d] !== 1'b1 || outValid[d] !== 1'b0) begin errors++;
            $display("FAIL fill_start dut%0d: got r=%b v=%b want r=1 v=0", d, inReady[d],
                     outValid[d]); end
        step();
        inData = 8'h06; inCtrl = 2'd2;
        @(negedge clk);
        checks++; if (outValid[d] !== 1'b1 || outData[d] !== 8'h05 || outCtrl[d] !== 2'd1) begin
            errors++;
            $display("FAIL fill_head dut%0d: got v=%b d=%h c=%b want v=1 d=05 c=01", d,
                     outValid[d], outData[d], outCtrl[d]); end
        checks++; if (inReady[d] !== skid) begin errors++;
            $display("FAIL fill_in_ready1 dut%0d: got %b want %b", d, inReady[d], skid); end
        step();
        if (skid) inValid = 1'b0;
        @(negedge clk);
        checks++; if (inReady[d] !== 1'b0 || outData[d] !== 8'h05) begin errors++;
            $display("FAIL fill_held dut%0d: got r=%b d=%h want r=0 d=05", d, inReady[d],
                     outData[d]); end
        checks++; if (stallCnt[d] !== 16'd1) begin errors++;
            $display("FAIL fill_stall1 dut%0d: got %0d want 1", d, stallCnt[d]); end
        step();
        outReady = 1'b1;
        @(negedge clk);
        checks++; if (outData[d] !== 8'h05 || stallCnt[d] !== 16'd2) begin errors++;
            $display("FAIL fill_release dut%0d: got d=%h s=%0d want d=05 s=2", d, outData[d],
                     stallCnt[d]); end
        checks++; if (inReady[d] !== !skid) begin errors++;
            $display("FAIL fill_in_ready2 dut%0d: got %b want %b", d, inReady[d], !skid); end
        step();
        inValid = 1'b0;
        @(negedge clk);
        checks++; if (outValid[d] !== 1'b1 || outData[d] !== 8'h06 || outCtrl[d] !== 2'd2) begin
            errors++;
            $display("FAIL fill_second dut%0d: got v=%b d=%h c=%b want v=1 d=06 c=10", d,
                     outValid[d], outData[d], outCtrl[d]); end
        checks++; if (inReady[d] !== 1'b1 || stallCnt[d] !== 16'd2) begin errors++;
            $display("FAIL fill_second_state dut%0d: got r=%b s=%0d want r=1 s=2", d,
                     inReady[d], stallCnt[d]); end
        step();
        @(negedge clk);
        checks++; if (outValid[d] !== 1'b0 || outCtrl[d] !== 2'b00 || inReady[d] !== 1'b1) begin
            errors++;
            $display("FAIL fill_empty dut%0d: got v=%b c=%b r=%b want v=0 c=00 r=1", d,
                     outValid[d], outCtrl[d], inReady[d]); end
    endtask

    task automatic test_flush(input int d);
        applyReset();
        outReady = 1'b0; inValid = 1'b1; inData = 8'hA1; inCtrl = 2'd1;
        step();
        inData = 8'hA2; inCtrl = 2'd2;
        step();
        inData = 8'hA3; inCtrl = 2'b11; flush = 1'b1;
        @(negedge clk);
        checks++; if (inReady[d] !== 1'b0 || outData[d] !== 8'hA1) begin errors++;
            $display("FAIL flush_pre dut%0d: got r=%b d=%h want r=0 d=a1", d, inReady[d],
                     outData[d]); end
        step();
        flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
        @(negedge clk);
        checks++; if (outValid[d] !== 1'b0 || outCtrl[d] !== 2'b00 || inReady[d] !== 1'b1) begin
            errors++;
            $display("FAIL flush_post dut%0d: got v=%b c=%b r=%b want v=0 c=00 r=1", d,
                     outValid[d], outCtrl[d], inReady[d]); end
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            checks++; if (outValid[d] !== 1'b0) begin errors++;
                $display("FAIL flush_leak dut%0d i=%0d: got %b want 0", d, i, outValid[d]); end
        end
        step();
        inValid = 1'b1; inData = 8'hB0; inCtrl = 2'b11; flush = 1'b1;
        @(negedge clk);
        checks++; if (inReady[d] !== 1'b1) begin errors++;
            $display("FAIL flush_fire_ready dut%0d: got %b want 1", d, inReady[d]); end
        step();
        flush = 1'b0; inValid = 1'b0;
        @(negedge clk);
        checks++; if (outValid[d] !== 1'b0 || outCtrl[d] !== 2'b00) begin errors++;
            $display("FAIL flush_beats_in dut%0d: got v=%b c=%b want v=0 c=00", d, outValid[d],
                     outCtrl[d]); end
        step();
        inValid = 1'b1; inData = 8'hC5; inCtrl = 2'd1;
        step();
        inValid = 1'b0;
        @(negedge clk);
        checks++; if (outValid[d] !== 1'b1 || outData[d] !== 8'hC5) begin errors++;
            $display("FAIL flush_resume dut%0d: got v=%b d=%h want v=1 d=c5", d, outValid[d],
                     outData[d]); end
    endtask

    task automatic test_async_reset();
        applyReset();
        outReady = 1'b0; inValid = 1'b1; inData = 8'hD1; inCtrl = 2'd1;
        step();
        inData = 8'hD2; inCtrl = 2'd2;
        step();
        inValid = 1'b0;
        step();
        @(negedge clk);
        checks++; if (stallCnt[0] !== 16'd2 || inReady[0] !== 1'b0 || outCtrl[0] !== 2'd1) begin
            errors++;
            $display("FAIL areset_pre: got s=%0d r=%b c=%b want s=2 r=0 c=01", stallCnt[0],
                     inReady[0], outCtrl[0]); end
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++; if (outValid[d] !== 1'b0 || outCtrl[d] !== 2'b00 || inReady[d] !== 1'b1)
            begin errors++;
                $display("FAIL areset_now dut%0d: got v=%b c=%b r=%b want v=0 c=00 r=1", d,
                         outValid[d], outCtrl[d], inReady[d]); end
            checks++; if (stallCnt[d] !== 16'd0) begin errors++;
                $display("FAIL areset_stall dut%0d: got %0d want 0", d, stallCnt[d]); end
        end
        #1 reset = 1'b1;
        step();
        @(negedge clk);
        checks++; if (outValid[0] !== 1'b0) begin errors++;
            $display("FAIL areset_lost: got %b want 0", outValid[0]); end
    endtask

    task automatic test_saturation();
        applyReset();
        outReady = 1'b0; inValid = 1'b1; inData = 8'h77; inCtrl = 2'd1;
        step();
        inValid = 1'b0;
        repeat (14) step();
        @(negedge clk);
        checks++; if (stallC !== 4'd14) begin errors++;
            $display("FAIL sat_14: got %0d want 14", stallC); end
        step();
        @(negedge clk);
        checks++; if (stallC !== 4'd15) begin errors++;
            $display("FAIL sat_15: got %0d want 15", stallC); end
        repeat (5) step();
        @(negedge clk);
        checks++; if (stallC !== 4'd15) begin errors++;
            $display("FAIL sat_hold: got %0d want 15", stallC); end
        checks++; if (stallCnt[0] !== 16'd20 || stallCnt[1] !== 16'd20) begin errors++;
            $display("FAIL sat_wide: got %0d/%0d want 20", stallCnt[0], stallCnt[1]); end
        checks++; if (outValid[2] !== 1'b1 || outData[2] !== 8'h77) begin errors++;
            $display("FAIL sat_head: got v=%b d=%h want v=1 d=77", outValid[2], outData[2]); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream(0);
        test_stream(1);
        test_stall_fill(0);
        test_stall_fill(1);
        test_flush(0);
        test_flush(1);
        test_async_reset();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
